base_endian_pipe: RTL
=====================

Name: base_endian_pipe

Overview:
- Pipelined, flow-controlled byte-order converter for a bytes-wide data path with a byte-enable sideband.
- Each beat carries its own swap mode: pass-through, or reversal within 2-, 4-, 8-, ... byte groups.
- Sits between host-interface logic and internal data paths where mixed-endian traffic must be normalised per transaction.
- Full throughput; fully registered output side; ready to the upstream port is registered through a 2-entry skid buffer.

Parameters:
- bytes, 8, data width in bytes. Must be a power of 2, range 1..64.
- mode_width, 3, width of the per-beat mode field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_v  input  1  input beat valid.
- i_r  output  1  ready to accept an input beat (registered).
- i_mode  input  mode_width  swap mode for this beat; group size is 2^i_mode bytes.
- i_d  input  [0:8*bytes-1]  input data; byte k occupies bits 8k..8k+7, byte 0 is most significant.
- i_be  input  [0:bytes-1]  byte enables; bit k qualifies byte k.
- o_v  output  1  output beat valid.
- o_r  input  1  downstream ready.
- o_d  output  [0:8*bytes-1]  converted data.
- o_be  output  [0:bytes-1]  converted byte enables.

Behaviour:
- Reset (async assert, release sync to clk): o_v=0, o_d=0, o_be=0, skid buffer empty, i_r=1.
- Swap function:
  - Group size g = 2^i_mode, clamped to bytes; i_mode=0 is pass-through.
  - Within each aligned group of g bytes, byte at offset j moves to offset g-1-j.
  - i_be is permuted identically, bit-for-bit with its byte.
  - The function is purely combinational on the input side and is applied before any storage.
- Handshake:
  - Input transfer when i_v & i_r; output transfer when o_v & o_r.
  - o_v/o_d/o_be hold stable while o_v=1 and o_r=0.
- Storage: an output register (main) plus one skid register.
  - Latency is exactly 1 cycle from an accepted input to o_v when main is empty or draining.
  - Accept while main is empty, or main is transferring this cycle with the skid empty: converted beat loads main.
  - Accept while main is full and stalled (o_r=0): converted beat loads the skid. Next cycle i_r=0.
  - Skid full and main transferring: skid moves into main; i_r returns to 1 the following cycle.
  - i_r is the registered complement of skid-valid and never depends combinationally on o_r.
- Ordering: beats exit strictly in acceptance order; no beat is dropped or duplicated.
- Simultaneous accept and drain with main full and skid empty: main reloads directly from the new beat; occupancy is unchanged.
- i_v with i_r=0: no state change; upstream holds the beat.
- Reset mid-stream: all in-flight beats are discarded and no partial output appears. After release, accept resumes on the first cycle.
- bytes=1: every mode is pass-through; handshake behaviour is unchanged.

Test Plan:
1. bytes=8, o_r=1, beat i_d=0x0011223344556677, i_be=0b10000000, i_mode=3 -> one cycle later o_v=1, o_d=0x7766554433221100, o_be=0b00000001.
2. Same data with i_mode=1 -> o_d=0x1100332255447766; i_mode=2 -> 0x3322110077665544; i_mode=0 -> unchanged; i_mode=5 -> same as mode 3.
3. Back-to-back 16 beats with o_r=1 -> 16 output beats on 16 consecutive cycles, in order, i_r constantly 1.
4. Stream with o_r held 0 for 4 cycles -> main plus skid hold 2 beats; i_r drops the cycle after the second accept; o_d stable; on o_r=1 both beats emerge in order and i_r returns to 1.
5. Assert reset while skid is full -> o_v=0, i_r=1, o_d=0 immediately; no pre-reset beat appears after release.
6. Randomised i_v/o_r at 50% with a scoreboard against a reference swap model over 10000 beats -> zero mismatches and zero loss.

Source files
------------

// File: rtl/base_endian_pipe.sv
// rtl/base_endian_pipe.sv - flow-controlled per-beat byte-order converter with skid buffer
// Byte 0 is the most significant byte of i_d/o_d; byte-enable bit k follows byte k.
module base_endian_pipe #(
  parameter int bytes      = 8,
  parameter int mode_width = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [mode_width-1:0] i_mode,
  input  logic [0:8*bytes-1]    i_d,
  input  logic [0:bytes-1]      i_be,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [0:8*bytes-1]    o_d,
  output logic [0:bytes-1]      o_be
);

  localparam int unsigned log_bytes = $clog2(bytes);
  localparam int unsigned lvl_w     = (log_bytes > 0) ? $clog2(log_bytes + 1) : 1;

  // Group level is the mode clamped so that a group never exceeds the bus width.
  logic [lvl_w-1:0]      lvl;
  logic [0:8*bytes-1]    sw_d;
  logic [0:bytes-1]      sw_be;

  always_comb begin
    lvl = '0;
    if (32'(i_mode) >= 32'(log_bytes))
      lvl = lvl_w'(log_bytes);
    else
      lvl = lvl_w'(i_mode);
  end

  // Reversal inside an aligned group of 2^l bytes maps offset k to k ^ (2^l - 1),
  // so each output byte just picks one precomputed source per level.
  for (genvar k = 0; k < bytes; k++) begin : g_byte
    logic [7:0] cand_d  [0:log_bytes];
    logic       cand_be [0:log_bytes];
    for (genvar l = 0; l <= int'(log_bytes); l++) begin : g_lvl
      localparam int src = k ^ ((1 << l) - 1);
      assign cand_d[l]  = i_d[8*src +: 8];
      assign cand_be[l] = i_be[src];
    end
    assign sw_d[8*k +: 8] = cand_d[lvl];
    assign sw_be[k]       = cand_be[lvl];
  end

  logic                 main_v;
  logic [0:8*bytes-1]   main_d;
  logic [0:bytes-1]     main_be;
  logic                 skid_v;
  logic [0:8*bytes-1]   skid_d;
  logic [0:bytes-1]     skid_be;
  logic                 rdy;

  logic accept;
  logic drain;

  assign accept = i_v & rdy;
  assign drain  = main_v & o_r;

  // rdy mirrors ~skid_v one register later, so upstream never sees o_r combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v  <= 1'b0;
      main_d  <= '0;
      main_be <= '0;
      skid_v  <= 1'b0;
      skid_d  <= '0;
      skid_be <= '0;
      rdy     <= 1'b1;
    end else begin
      if (skid_v) begin
        if (drain) begin
          main_d  <= skid_d;
          main_be <= skid_be;
          skid_v  <= 1'b0;
          rdy     <= 1'b1;
        end
      end else if (accept) begin
        if (!main_v || o_r) begin
          main_v  <= 1'b1;
          main_d  <= sw_d;
          main_be <= sw_be;
        end else begin
          skid_v  <= 1'b1;
          skid_d  <= sw_d;
          skid_be <= sw_be;
          rdy     <= 1'b0;
        end
      end else if (drain) begin
        main_v <= 1'b0;
      end
    end
  end

  assign i_r  = rdy;
  assign o_v  = main_v;
  assign o_d  = main_d;
  assign o_be = main_be;

endmodule
